// File: rtl/stats_pkg.sv
// Shared helpers for the sliding-window statistics engine.
//   - Default geometry (WINDOW, DATA_WIDTH).
//   - log2w(): shift amount that turns a window sum into a mean.
//   - is_pow2(): elaboration-time legality check for WINDOW.
//   - sum_w()/sqsum_w(): accumulator widths wide enough that a full window
//     of maximum-valued samples never overflows.
package stats_pkg;

    localparam int DEF_WINDOW     = 4;
    localparam int DEF_DATA_WIDTH = 8;

    function automatic int log2w(input int window);
        return $clog2(window);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // Sum of WINDOW samples: DATA_WIDTH + LOG2W bits.
    function automatic int sum_w(input int data_width, input int window);
        return data_width + log2w(window);
    endfunction

    // Sum of WINDOW squared samples: 2*DATA_WIDTH + LOG2W bits.
    function automatic int sqsum_w(input int data_width, input int window);
        return 2 * data_width + log2w(window);
    endfunction

endpackage

// File: rtl/win_variance_if.sv
// Sample/result bundle of the sliding-window statistics engine.
//   enable, clear, data_in                  : sample side (master drives)
//   data_valid, mean_out, sec_mom_out,
//   var_out, window_full                    : result side (slave drives)
interface win_variance_if
    import stats_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                      enable;
    logic                      clear;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      data_valid;
    logic [DATA_WIDTH-1:0]     mean_out;
    logic [2*DATA_WIDTH-1:0]   sec_mom_out;
    logic [2*DATA_WIDTH-1:0]   var_out;
    logic                      window_full;

    modport master (
        output enable, clear, data_in,
        input  data_valid, mean_out, sec_mom_out, var_out, window_full
    );

    modport slave (
        input  enable, clear, data_in,
        output data_valid, mean_out, sec_mom_out, var_out, window_full
    );
endinterface

// File: rtl/win_sq_acc.sv
// Stage S1 of the window statistics pipeline: WINDOW-deep sample shift
// register, saturating fill counter and running sum / sum-of-squares.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   enable, data_in   sample accepted this cycle
//   clear             restart the window (enable+clear loads data_in as entry 0)
//   x_sum, x_sqsum    running sum and sum of squares of the window contents
//   full              registered (fill count == WINDOW)
//   s1_valid          a sample was accepted and the window is full after it
module win_sq_acc
    import stats_pkg::*;
#(
    parameter  int WINDOW     = DEF_WINDOW,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int SUM_W      = sum_w(DATA_WIDTH, WINDOW),
    localparam int SQSUM_W    = sqsum_w(DATA_WIDTH, WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [SUM_W-1:0]      x_sum,
    output logic [SQSUM_W-1:0]    x_sqsum,
    output logic                  full,
    output logic                  s1_valid
);
    localparam int LOG2W  = log2w(WINDOW);
    localparam int CNT_W  = LOG2W + 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(WINDOW);

    // Entry 0 is the newest sample, entry WINDOW-1 the one about to leave.
    logic [WINDOW-1:0][DATA_WIDTH-1:0] fifo_reg, fifo_next;
    logic [SUM_W-1:0]   sum_reg, sum_next;
    logic [SQSUM_W-1:0] sqsum_reg, sqsum_next;
    logic [CNT_W-1:0]   fill_reg, fill_next;
    logic               full_reg, s1_valid_reg;

    logic [DATA_WIDTH-1:0] x_old;
    logic [PROD_W-1:0]     x_sq, x_old_sq;

    // The FIFO starts zeroed, so during warm-up x_old is 0 and the
    // subtraction below leaves the accumulators exact.
    assign x_old    = fifo_reg[WINDOW-1];
    assign x_sq     = PROD_W'(data_in) * PROD_W'(data_in);
    assign x_old_sq = PROD_W'(x_old) * PROD_W'(x_old);

    genvar gi;
    generate
        for (gi = 0; gi < WINDOW; gi++) begin : g_fifo
            if (gi == 0) begin : g_head
                assign fifo_next[gi] = enable ? data_in
                                     : (clear ? '0 : fifo_reg[gi]);
            end else begin : g_tail
                assign fifo_next[gi] = clear  ? '0
                                     : (enable ? fifo_reg[gi-1] : fifo_reg[gi]);
            end
        end
    endgenerate

    always_comb begin
        sum_next   = sum_reg;
        sqsum_next = sqsum_reg;
        fill_next  = fill_reg;
        if (clear) begin
            sum_next   = enable ? SUM_W'(data_in) : '0;
            sqsum_next = enable ? SQSUM_W'(x_sq)  : '0;
            fill_next  = enable ? CNT_W'(1)       : '0;
        end else if (enable) begin
            sum_next   = sum_reg + SUM_W'(data_in) - SUM_W'(x_old);
            sqsum_next = sqsum_reg + SQSUM_W'(x_sq) - SQSUM_W'(x_old_sq);
            if (fill_reg != FILL_MAX) begin
                fill_next = fill_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_reg     <= '0;
            sum_reg      <= '0;
            sqsum_reg    <= '0;
            fill_reg     <= '0;
            full_reg     <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            fifo_reg     <= fifo_next;
            sum_reg      <= sum_next;
            sqsum_reg    <= sqsum_next;
            fill_reg     <= fill_next;
            full_reg     <= (fill_next == FILL_MAX);
            s1_valid_reg <= enable && (fill_next == FILL_MAX);
        end
    end

    assign x_sum    = sum_reg;
    assign x_sqsum  = sqsum_reg;
    assign full     = full_reg;
    assign s1_valid = s1_valid_reg;

endmodule

// File: rtl/win_variance.sv
// Sliding-window mean / second moment / variance over the last WINDOW
// unsigned samples. Three-edge latency from sample acceptance to the
// data_valid strobe; one sample per cycle throughput.
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset (priority over clear and enable)
//   bus  win_variance_if.slave: enable/clear/data_in in,
//        data_valid/mean_out/sec_mom_out/var_out/window_full out
module win_variance
    import stats_pkg::*;
#(
    parameter int WINDOW     = DEF_WINDOW,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic           clk,
    input logic           rst,
    win_variance_if.slave bus
);
    localparam int LOG2W   = log2w(WINDOW);
    localparam int SUM_W   = sum_w(DATA_WIDTH, WINDOW);
    localparam int SQSUM_W = sqsum_w(DATA_WIDTH, WINDOW);
    localparam int PROD_W  = 2 * DATA_WIDTH;

    generate
        if (!is_pow2(WINDOW)) begin : g_bad_window
            $error("win_variance: WINDOW must be a power of 2 and >= 2");
        end
    endgenerate

    logic [SUM_W-1:0]   acc_sum;
    logic [SQSUM_W-1:0] acc_sqsum;
    logic               acc_full;
    logic               acc_s1_valid;

    win_sq_acc #(
        .WINDOW     (WINDOW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .enable   (bus.enable),
        .clear    (bus.clear),
        .data_in  (bus.data_in),
        .x_sum    (acc_sum),
        .x_sqsum  (acc_sqsum),
        .full     (acc_full),
        .s1_valid (acc_s1_valid)
    );

    // S2: divide by WINDOW. The sum of WINDOW samples shifted by LOG2W
    // always fits back into DATA_WIDTH bits.
    logic                  s2_valid_reg;
    logic [DATA_WIDTH-1:0] s2_mean_reg;
    logic [PROD_W-1:0]     s2_m2_reg;

    // S3: output registers.
    logic                  data_valid_reg;
    logic [DATA_WIDTH-1:0] mean_reg;
    logic [PROD_W-1:0]     sec_mom_reg;
    logic [PROD_W-1:0]     var_reg;

    logic [PROD_W-1:0]     mean_sq;
    logic                  s3_load;

    assign mean_sq = PROD_W'(s2_mean_reg) * PROD_W'(s2_mean_reg);
    // floor(mean)^2 <= floor(m2), so the subtraction cannot go negative.
    // A clear drops whatever is in flight, including the S2 result.
    assign s3_load = s2_valid_reg && !bus.clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg   <= 1'b0;
            s2_mean_reg    <= '0;
            s2_m2_reg      <= '0;
            data_valid_reg <= 1'b0;
            mean_reg       <= '0;
            sec_mom_reg    <= '0;
            var_reg        <= '0;
        end else begin
            s2_valid_reg   <= acc_s1_valid && !bus.clear;
            s2_mean_reg    <= DATA_WIDTH'(acc_sum >> LOG2W);
            s2_m2_reg      <= PROD_W'(acc_sqsum >> LOG2W);
            data_valid_reg <= s3_load;
            if (s3_load) begin
                mean_reg    <= s2_mean_reg;
                sec_mom_reg <= s2_m2_reg;
                var_reg     <= s2_m2_reg - mean_sq;
            end
        end
    end

    assign bus.data_valid  = data_valid_reg;
    assign bus.mean_out    = mean_reg;
    assign bus.sec_mom_out = sec_mom_reg;
    assign bus.var_out     = var_reg;
    assign bus.window_full = acc_full;

endmodule

// File: tb/tb_win_variance.sv
// Directed bench for win_variance (WINDOW=4, DATA_WIDTH=8). Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, so
// every check sees the state produced by the edge just taken.
module tb_win_variance;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    win_variance_if #(.DATA_WIDTH(8)) bus ();

    win_variance #(
        .WINDOW     (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic dv, input logic [7:0] mean,
                             input logic [15:0] sec, input logic [15:0] var_exp,
                             input logic full);
        check({tag, ".data_valid"},  32'(bus.data_valid),  32'(dv));
        check({tag, ".mean_out"},    32'(bus.mean_out),    32'(mean));
        check({tag, ".sec_mom_out"}, 32'(bus.sec_mom_out), 32'(sec));
        check({tag, ".var_out"},     32'(bus.var_out),     32'(var_exp));
        check({tag, ".window_full"}, 32'(bus.window_full), 32'(full));
    endtask

    // One clock edge with the given inputs applied; one line per transaction.
    task automatic step(input logic en, input logic clr, input logic [7:0] x);
        bus.enable  = en;
        bus.clear   = clr;
        bus.data_in = x;
        @(posedge clk);
        #1;
        $display("[%0t] rst=%0b en=%0b clr=%0b x=%0d -> dv=%0b mean=%0d sec=%0d var=%0d full=%0b",
                 $time, rst, en, clr, x, bus.data_valid, bus.mean_out,
                 bus.sec_mom_out, bus.var_out, bus.window_full);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;

        // Reset state
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        check_out("reset", 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        rst = 1'b0;

        // Fill 2,4,6,8: no strobe during warm-up, one strobe 3 edges after the 8
        step(1'b1, 1'b0, 8'd2);
        check("fill.s1.dv", 32'(bus.data_valid), 32'd0);
        step(1'b1, 1'b0, 8'd4);
        check("fill.s2.dv", 32'(bus.data_valid), 32'd0);
        step(1'b1, 1'b0, 8'd6);
        check_out("fill.s3", 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 8'd8);
        check_out("fill.s4", 1'b0, 8'd0, 16'd0, 16'd0, 1'b1);
        idle();
        check("fill.lat2.dv", 32'(bus.data_valid), 32'd0);
        idle();
        check_out("fill.result", 1'b1, 8'd5, 16'd30, 16'd5, 1'b1);
        idle();
        check_out("fill.hold", 1'b0, 8'd5, 16'd30, 16'd5, 1'b1);

        // Slide: window becomes 4,6,8,10
        step(1'b1, 1'b0, 8'd10);
        check("slide.s1.dv", 32'(bus.data_valid), 32'd0);
        idle();
        idle();
        check_out("slide.result", 1'b1, 8'd7, 16'd54, 16'd5, 1'b1);

        // Maximum samples: accumulators must not overflow
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd255);
        idle();
        idle();
        check_out("max.result", 1'b1, 8'd255, 16'd65025, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd0);
        idle();
        idle();
        check_out("zero.result", 1'b1, 8'd0, 16'd0, 16'd0, 1'b1);

        // Truncation: 1,2,1,2 -> mean 1, sec 2, var 1
        step(1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b0, 8'd2);
        idle();
        idle();
        check_out("trunc.result", 1'b1, 8'd1, 16'd2, 16'd1, 1'b1);

        // Bubbles after a clear: 2,_,4,_,6,_,8
        step(1'b0, 1'b1, 8'd0);
        check_out("bub.clear", 1'b0, 8'd1, 16'd2, 16'd1, 1'b0);
        step(1'b1, 1'b0, 8'd2);
        check("bub.s1.dv", 32'(bus.data_valid), 32'd0);
        idle();
        check_out("bub.gap1", 1'b0, 8'd1, 16'd2, 16'd1, 1'b0);
        step(1'b1, 1'b0, 8'd4);
        idle();
        step(1'b1, 1'b0, 8'd6);
        idle();
        check_out("bub.gap3", 1'b0, 8'd1, 16'd2, 16'd1, 1'b0);
        step(1'b1, 1'b0, 8'd8);
        check_out("bub.s4", 1'b0, 8'd1, 16'd2, 16'd1, 1'b1);
        idle();
        check("bub.lat2.dv", 32'(bus.data_valid), 32'd0);
        idle();
        check_out("bub.result", 1'b1, 8'd5, 16'd30, 16'd5, 1'b1);

        // Clear with enable while a result is in flight
        step(1'b0, 1'b1, 8'd0);
        step(1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 8'd4);
        step(1'b1, 1'b0, 8'd6);
        step(1'b1, 1'b0, 8'd8);
        check("clr.fill.full", 32'(bus.window_full), 32'd1);
        step(1'b1, 1'b1, 8'd9);
        check_out("clr.edge", 1'b0, 8'd5, 16'd30, 16'd5, 1'b0);
        idle();
        check_out("clr.dropped", 1'b0, 8'd5, 16'd30, 16'd5, 1'b0);
        step(1'b1, 1'b0, 8'd9);
        check("clr.9b.dv", 32'(bus.data_valid), 32'd0);
        step(1'b1, 1'b0, 8'd9);
        check("clr.9c.full", 32'(bus.window_full), 32'd0);
        step(1'b1, 1'b0, 8'd9);
        check_out("clr.9d", 1'b0, 8'd5, 16'd30, 16'd5, 1'b1);
        idle();
        check("clr.lat2.dv", 32'(bus.data_valid), 32'd0);
        idle();
        check_out("clr.result", 1'b1, 8'd9, 16'd81, 16'd0, 1'b1);

        // Reset mid-stream: results in flight are lost, outputs zero
        step(1'b1, 1'b0, 8'd3);
        step(1'b1, 1'b0, 8'd3);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'd3);
        check_out("rst.mid", 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check_out("rst.after", 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
